// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data access. Data has priority, with a streak limit so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int LAT        = 1,
  parameter int MAX_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [2:0] LAT_C    = 3'(LAT);
  localparam logic [2:0] STREAK_C = 3'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [31:0]         wdata_reg;
  logic [2:0]          func3_reg;
  logic [2:0]          streak_reg, streak_next;
  logic [2:0]          cnt_reg;
  logic                mem_en_reg;
  logic                if_ack_reg, d_ack_reg;
  logic [31:0]         if_rdata_reg, d_rdata_reg;

  logic                grant_data;
  logic                load;
  logic                capture;

  // Data wins unless fetch has already waited through a full streak.
  assign grant_data = d_req & ~(if_req & (streak_reg == STREAK_C));

  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    capture     = 1'b0;
    streak_next = streak_reg;
    case (state_reg)
      IDLE: begin
        if (if_req | d_req) begin
          load       = 1'b1;
          state_next = ACCESS;
          if (grant_data && if_req)
            streak_next = (streak_reg == STREAK_C) ? streak_reg : streak_reg + 3'd1;
          else
            streak_next = 3'd0;
        end
      end
      ACCESS: state_next = WAIT;
      WAIT: begin
        // Counter hits zero on this decrement: mem_rdata is valid now.
        if (cnt_reg == 3'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      func3_reg    <= '0;
      streak_reg   <= '0;
      cnt_reg      <= '0;
      mem_en_reg   <= 1'b0;
      if_ack_reg   <= 1'b0;
      d_ack_reg    <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mem_en_reg <= load;
      if (load) begin
        owner_reg  <= grant_data;
        addr_reg   <= grant_data ? d_addr : if_addr;
        we_reg     <= grant_data & d_we;
        wdata_reg  <= d_wdata;
        func3_reg  <= grant_data ? d_func3 : 3'b010;
        streak_reg <= streak_next;
      end
      if (state_reg == ACCESS)
        cnt_reg <= LAT_C;
      else if (state_reg == WAIT)
        cnt_reg <= cnt_reg - 3'd1;
      if_ack_reg <= capture & ~owner_reg;
      d_ack_reg  <= capture & owner_reg;
      if (capture && !owner_reg)
        if_rdata_reg <= mem_rdata;
      // Stores complete through the same path but keep the last load value.
      if (capture && owner_reg && !we_reg)
        d_rdata_reg <= mem_rdata;
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_func3 = func3_reg;
  assign if_ack    = if_ack_reg;
  assign d_ack     = d_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_stall  = if_req & ~if_ack_reg;
  assign d_stall   = d_req & ~d_ack_reg;
  assign busy      = (state_reg != IDLE);
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=1 instance and a LAT=3 instance share the
// requester inputs; each has its own memory model that drives data only in the valid cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_func3 = '0;

  logic        if_ack_a, if_stall_a, d_ack_a, d_stall_a, mem_en_a, mem_we_a, busy_a, owner_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [11:0] mem_addr_a;
  logic [2:0]  mem_func3_a;
  logic        if_ack_b, if_stall_b, d_ack_b, d_stall_b, mem_en_b, mem_we_b, busy_b, owner_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [11:0] mem_addr_b;
  logic [2:0]  mem_func3_b;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .LAT(1), .MAX_STREAK(2)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_a), .if_rdata(if_rdata_a), .if_stall(if_stall_a),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_stall(d_stall_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_func3(mem_func3_a), .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a)
  );

  mem_port_arbiter #(.ADDR_W(12), .LAT(3), .MAX_STREAK(2)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_b), .if_rdata(if_rdata_b), .if_stall(if_stall_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_stall(d_stall_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_func3(mem_func3_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
  );

  function automatic logic [31:0] memf(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  // Memory models: rdata is valid exactly LAT cycles after mem_en, garbage otherwise.
  logic [2:0]  cd_a = '0, cd_b = '0;
  logic [11:0] la_a = '0, la_b = '0;
  always @(posedge clk) begin
    if (!rst) begin
      cd_a <= '0; cd_b <= '0;
    end else begin
      if (mem_en_a) begin cd_a <= 3'd1; la_a <= mem_addr_a; end
      else if (cd_a != 0) cd_a <= cd_a - 3'd1;
      if (mem_en_b) begin cd_b <= 3'd3; la_b <= mem_addr_b; end
      else if (cd_b != 0) cd_b <= cd_b - 3'd1;
    end
  end
  assign mem_rdata_a = (cd_a == 3'd1) ? memf(la_a) : 32'hBAD0BAD0;
  assign mem_rdata_b = (cd_b == 3'd1) ? memf(la_b) : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                       input logic [11:0] da, input logic [31:0] dwd, input logic [2:0] df);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_func3 = df;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 3'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [11:0] daddr;
    logic [31:0] dwdata;
    logic [2:0]  df3;
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        iack;
    logic        dack;
    logic [31:0] drd;
    logic        busy;
    logic        owner;
    logic        istall;
    logic        dstall;
  } vec_t;

  vec_t tbl[10];
  logic exp_own[6];

  initial begin
    // Load 0x010 (lbu code) then store 0x020 on the LAT=1 instance, one row per cycle.
    tbl[0] = '{0, 1, 0, 12'h010, 32'h0, 3'b100, 0, 0, 12'h000, 32'h0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 12'h010, 32'h0, 3'b100, 1, 0, 12'h010, 32'h0, 3'b100, 0, 0, 32'h0, 1, 1, 0, 1};
    tbl[2] = '{0, 1, 0, 12'h010, 32'h0, 3'b100, 0, 0, 12'h010, 32'h0, 3'b100, 0, 0, 32'h0, 1, 1, 0, 1};
    tbl[3] = '{0, 1, 0, 12'h010, 32'h0, 3'b100, 0, 0, 12'h010, 32'h0, 3'b100, 0, 1, 32'hDEADBEEF, 1, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 12'h010, 32'h0, 3'b100, 0, 0, 12'h010, 32'h0, 3'b100, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 1, 12'h020, 32'h12345678, 3'b000, 0, 0, 12'h010, 32'h0, 3'b100, 0, 0, 32'hDEADBEEF, 0, 1, 0, 1};
    tbl[6] = '{0, 1, 1, 12'h020, 32'h12345678, 3'b000, 1, 1, 12'h020, 32'h12345678, 3'b000, 0, 0, 32'hDEADBEEF, 1, 1, 0, 1};
    tbl[7] = '{0, 1, 1, 12'h020, 32'h12345678, 3'b000, 0, 1, 12'h020, 32'h12345678, 3'b000, 0, 0, 32'hDEADBEEF, 1, 1, 0, 1};
    tbl[8] = '{0, 1, 1, 12'h020, 32'h12345678, 3'b000, 0, 1, 12'h020, 32'h12345678, 3'b000, 0, 1, 32'hDEADBEEF, 1, 1, 0, 0};
    tbl[9] = '{0, 0, 0, 12'h020, 32'h12345678, 3'b000, 0, 1, 12'h020, 32'h12345678, 3'b000, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0};
    exp_own = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].ireq, 12'h0, tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwdata, tbl[i].df3);
      #1;
      check($sformatf("vec%0d.mem_en", i), mem_en_a, tbl[i].en);
      check($sformatf("vec%0d.mem_we", i), mem_we_a, tbl[i].we);
      check($sformatf("vec%0d.mem_addr", i), mem_addr_a, tbl[i].addr);
      check($sformatf("vec%0d.mem_wdata", i), mem_wdata_a, tbl[i].wdata);
      check($sformatf("vec%0d.mem_func3", i), mem_func3_a, tbl[i].f3);
      check($sformatf("vec%0d.if_ack", i), if_ack_a, tbl[i].iack);
      check($sformatf("vec%0d.d_ack", i), d_ack_a, tbl[i].dack);
      check($sformatf("vec%0d.d_rdata", i), d_rdata_a, tbl[i].drd);
      check($sformatf("vec%0d.busy", i), busy_a, tbl[i].busy);
      check($sformatf("vec%0d.owner", i), owner_a, tbl[i].owner);
      check($sformatf("vec%0d.if_stall", i), if_stall_a, tbl[i].istall);
      check($sformatf("vec%0d.d_stall", i), d_stall_a, tbl[i].dstall);
      $display("[TB] vec%0d dreq=%0b we=%0b addr=%h -> en=%0b dack=%0b drd=%h busy=%0b", i,
               tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, mem_en_a, d_ack_a, d_rdata_a, busy_a);
    end

    // Both requesters held: grant order must be D, D, F, D, D, F.
    do_reset();
    begin
      int g = 0;
      for (int c = 0; c < 60 && g < 6; c++) begin
        @(negedge clk);
        drive(1'b1, 12'h100, 1'b1, 1'b0, 12'h200, 32'h0, 3'b010);
        #1;
        if (mem_en_a) begin
          check($sformatf("streak.grant%0d.owner", g), owner_a, exp_own[g]);
          $display("[TB] streak grant%0d owner=%0b addr=%h", g, owner_a, mem_addr_a);
          g++;
        end
        check($sformatf("streak.c%0d.if_stall", c), if_stall_a, !if_ack_a);
        if (if_ack_a) check("streak.if_rdata", if_rdata_a, memf(12'h100));
        if (d_ack_a)  check("streak.d_rdata", d_rdata_a, memf(12'h200));
      end
      check("streak.grants_seen", g, 6);
    end

    // LAT=3 fetch: mem_en cycle 1, ack cycle 5, busy 1..5.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(c < 6, 12'h004, 1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
      #1;
      check($sformatf("lat3.c%0d.mem_en", c), mem_en_b, c == 1);
      check($sformatf("lat3.c%0d.if_ack", c), if_ack_b, c == 5);
      check($sformatf("lat3.c%0d.busy", c), busy_b, (c >= 1) && (c <= 5));
      if (c == 1) check("lat3.mem_func3", mem_func3_b, 3'b010);
      if (c == 1) check("lat3.mem_addr", mem_addr_b, 12'h004);
      if (c == 5) check("lat3.if_rdata", if_rdata_b, memf(12'h004));
      $display("[TB] lat3 c%0d en=%0b ack=%0b busy=%0b rdata=%h", c, mem_en_b, if_ack_b, busy_b, if_rdata_b);
    end

    // Reset during WAIT on the LAT=3 instance.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h010, 32'hA5A5A5A5, 3'b010);
    end
    @(negedge clk);
    check("rstwait.busy_before", busy_b, 1'b1);
    rst = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
    #1;
    check("rstwait.busy", busy_b, 1'b0);
    check("rstwait.mem_we", mem_we_b, 1'b0);
    check("rstwait.mem_addr", mem_addr_b, 12'h0);
    check("rstwait.mem_wdata", mem_wdata_b, 32'h0);
    check("rstwait.mem_func3", mem_func3_b, 3'b000);
    check("rstwait.owner", owner_b, 1'b0);
    check("rstwait.d_ack", d_ack_b, 1'b0);
    $display("[TB] reset in WAIT busy=%0b owner=%0b addr=%h", busy_b, owner_b, mem_addr_b);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rstwait.post%0d.d_ack", c), d_ack_b, 1'b0);
      check($sformatf("rstwait.post%0d.busy", c), busy_b, 1'b0);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1'b0, 12'h0, c < 6, 1'b0, 12'h030, 32'h0, 3'b010);
      #1;
      check($sformatf("rstnew.c%0d.mem_en", c), mem_en_b, c == 1);
      check($sformatf("rstnew.c%0d.d_ack", c), d_ack_b, c == 5);
      if (c == 5) check("rstnew.d_rdata", d_rdata_b, memf(12'h030));
      $display("[TB] after-reset load c%0d en=%0b dack=%0b drd=%h", c, mem_en_b, d_ack_b, d_rdata_b);
    end

    // Fetch in flight, data arrives in cycle 2: fetch first, data granted after RESP.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(c < 4, 12'h040, (c >= 2) && (c < 8), 1'b0, 12'h050, 32'h0, 3'b010);
      #1;
      check($sformatf("f2d.c%0d.if_ack", c), if_ack_a, c == 3);
      check($sformatf("f2d.c%0d.d_ack", c), d_ack_a, c == 7);
      check($sformatf("f2d.c%0d.mem_en", c), mem_en_a, (c == 1) || (c == 5));
      if (c == 3) check("f2d.owner_fetch", owner_a, 1'b0);
      if (c == 3) check("f2d.if_rdata", if_rdata_a, memf(12'h040));
      if (c == 5) check("f2d.owner_data", owner_a, 1'b1);
      if (c == 5) check("f2d.mem_addr", mem_addr_a, 12'h050);
      if (c == 7) check("f2d.d_rdata", d_rdata_a, memf(12'h050));
      $display("[TB] f2d c%0d en=%0b owner=%0b iack=%0b dack=%0b", c, mem_en_a, owner_a, if_ack_a, d_ack_a);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
